// File: rtl/seq_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_match_ctrl
// Brief    : Run controller for the serial pattern-detection datapath.
//            Holds a programmable 1..MAX_LEN bit pattern, arms/disarms
//            detection, counts overlapping or non-overlapping matches and
//            stops at a programmed match target.
// Revision : 1.0 - initial release
// ============================================================================
module seq_match_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               abort,
  input  logic               data_valid,
  input  logic               data,
  output logic               match_pulse,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [LEN_W-1:0] HIST_FULL = LEN_W'(MAX_LEN);

  logic [1:0]         state;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [CNT_W-1:0]   target_q;
  logic [MAX_LEN-1:0] history;
  logic [LEN_W-1:0]   hist_cnt;

  logic [MAX_LEN-1:0] len_mask;
  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   hist_cnt_next;
  logic [CNT_W-1:0]   cnt_inc;
  logic               len_illegal;
  logic               match_now;

  // Mask selecting the low len_q bits of pattern and history.
  for (genvar g = 0; g < MAX_LEN; g++) begin : g_mask
    assign len_mask[g] = (32'(len_q) > g);
  end

  assign hist_next     = {history[MAX_LEN-2:0], data};
  assign hist_cnt_next = (hist_cnt == HIST_FULL) ? hist_cnt : hist_cnt + 1'b1;
  assign cnt_inc       = match_cnt + 1'b1;
  assign len_illegal   = (cfg_len == '0) || (32'(cfg_len) > MAX_LEN);

  // A match is judged on the history as it will look after this sample.
  assign match_now = (state == ST_RUN) && data_valid &&
                     (hist_cnt_next >= len_q) &&
                     (((hist_next ^ pattern_q) & len_mask) == '0);

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // State machine, configuration registers, history shifter and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pattern_q   <= '0;
      len_q       <= LEN_W'(1);
      overlap_q   <= 1'b0;
      target_q    <= '0;
      history     <= '0;
      hist_cnt    <= '0;
      match_pulse <= 1'b0;
      match_cnt   <= '0;
      cfg_err     <= 1'b0;
    end else begin
      match_pulse <= 1'b0;
      if (state == ST_RUN) begin
        // Abort discards any match completing in the same cycle.
        if (abort) begin
          state <= ST_IDLE;
        end else if (data_valid) begin
          history  <= hist_next;
          hist_cnt <= hist_cnt_next;
          if (match_now) begin
            match_pulse <= 1'b1;
            match_cnt   <= cnt_inc;
            if (!overlap_q) begin
              hist_cnt <= '0;
            end
            if ((target_q != '0) && (cnt_inc == target_q)) begin
              state <= ST_DONE;
            end
          end
        end
      end else begin
        // IDLE or DONE: configuration is writable, start arms a new run.
        if (abort) begin
          state <= ST_IDLE;
        end else if (start && !cfg_err) begin
          state     <= ST_RUN;
          match_cnt <= '0;
          history   <= '0;
          hist_cnt  <= '0;
        end
        if (cfg_we) begin
          pattern_q <= cfg_pattern;
          len_q     <= cfg_len;
          overlap_q <= cfg_overlap;
          target_q  <= cfg_target;
          cfg_err   <= len_illegal;
        end
      end
    end
  end

endmodule
`default_nettype wire
